// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - RV32M funct3 encodings (F3_MUL .. F3_REMU)
//   - FSM state enum (IDLE, CALC, FIX, DONE)
//   - ITER: number of shift-add / restoring-subtract iterations
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit feeding the register-file
// write port. Fixed latency of 34 cycles from the accepting edge to oDone.
// Ports:
//   iCLK, iRST          clock, asynchronous active-high reset
//   iStart              request, sampled only in IDLE
//   iFunct3             RV32M operation select
//   iRs1Data, iRs2Data  operands A and B
//   iRd                 destination register index
//   oBusy               high from the cycle after acceptance until oDone falls
//   oDone               one-cycle completion pulse, oResult valid
//   oRegWrite           oDone qualified by oRd != 0
//   oRd                 latched destination index
//   oResult             result, held until the next operation overwrites it
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  input  logic [4:0]      iRd,
  output logic            oBusy,
  output logic            oDone,
  output logic            oRegWrite,
  output logic [4:0]      oRd,
  output logic [XLEN-1:0] oResult
);

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [2:0]  f3_reg, f3_next;
  logic [4:0]  rd_reg, rd_next;
  logic [31:0] a_reg, a_next;        // |A|; shifted left while dividing
  logic [31:0] b_reg, b_next;        // |B|; shifted right while multiplying
  logic [63:0] acc_reg, acc_next;    // product, or {remainder, quotient}
  logic        neg_res_reg, neg_res_next;  // operand signs differ
  logic        neg_rem_reg, neg_rem_next;  // dividend negative
  logic        bzero_reg, bzero_next;
  logic        ovf_reg, ovf_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        regwr_reg, regwr_next;
  logic [31:0] result_reg, result_next;

  // Operand conditioning at acceptance
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_signed = !(iFunct3 == F3_MULHU || iFunct3 == F3_DIVU || iFunct3 == F3_REMU);
    b_signed = (iFunct3 == F3_MUL || iFunct3 == F3_MULH ||
                iFunct3 == F3_DIV || iFunct3 == F3_REM);
    sa       = a_signed & iRs1Data[31];
    sb       = b_signed & iRs2Data[31];
    a_mag    = sa ? (32'd0 - iRs1Data) : iRs1Data;
    b_mag    = sb ? (32'd0 - iRs2Data) : iRs2Data;
  end

  // One iteration of each datapath. The multiplier shifts the product right
  // so only a 32-bit adder is needed; the divider shifts the dividend in MSB
  // first and keeps the partial remainder in the upper half.
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[63:32]} + (b_reg[0] ? {1'b0, a_reg} : 33'd0);
    div_shift = {acc_reg[63:32], a_reg[31]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_diff  = div_shift - {1'b0, b_reg};
  end

  // Sign correction and result selection
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix = neg_res_reg ? (64'd0 - acc_reg) : acc_reg;
    if (bzero_reg)
      quo_fix = 32'hFFFF_FFFF;
    else if (ovf_reg)
      quo_fix = 32'h8000_0000;
    else
      quo_fix = neg_res_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
    // On divide by zero the remainder magnitude is |A|, so restoring the
    // dividend's sign returns A unmodified.
    if (ovf_reg)
      rem_fix = 32'd0;
    else
      rem_fix = neg_rem_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
    case (f3_reg)
      F3_MUL:                        fix_result = prod_fix[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_result = prod_fix[63:32];
      F3_DIV, F3_DIVU:               fix_result = quo_fix;
      default:                       fix_result = rem_fix;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    f3_next      = f3_reg;
    rd_next      = rd_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    neg_res_next = neg_res_reg;
    neg_rem_next = neg_rem_reg;
    bzero_next   = bzero_reg;
    ovf_next     = ovf_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    regwr_next   = 1'b0;
    result_next  = result_reg;

    // Busy falls with oDone unless a new operation is accepted the same edge.
    if (done_reg)
      busy_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (iStart) begin
          f3_next      = iFunct3;
          rd_next      = iRd;
          a_next       = a_mag;
          b_next       = b_mag;
          acc_next     = 64'd0;
          cnt_next     = 6'd0;
          neg_res_next = sa ^ sb;
          neg_rem_next = sa;
          bzero_next   = (iRs2Data == 32'd0);
          ovf_next     = iFunct3[2] & a_signed & b_signed &
                         (iRs1Data == 32'h8000_0000) & (iRs2Data == 32'hFFFF_FFFF);
          busy_next    = 1'b1;
          state_next   = CALC;
        end
      end
      CALC: begin
        if (f3_reg[2]) begin
          acc_next = {(div_ge ? div_diff[31:0] : div_shift[31:0]),
                      acc_reg[30:0], div_ge};
          a_next   = {a_reg[30:0], 1'b0};
        end else begin
          acc_next = {mul_sum, acc_reg[31:1]};
          b_next   = {1'b0, b_reg[31:1]};
        end
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == LAST_CNT)
          state_next = FIX;
      end
      FIX: begin
        result_next = fix_result;
        state_next  = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        regwr_next = (rd_reg != 5'd0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg   <= IDLE;
      cnt_reg     <= 6'd0;
      f3_reg      <= 3'd0;
      rd_reg      <= 5'd0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      acc_reg     <= 64'd0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      bzero_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      regwr_reg   <= 1'b0;
      result_reg  <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      f3_reg      <= f3_next;
      rd_reg      <= rd_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      neg_res_reg <= neg_res_next;
      neg_rem_reg <= neg_rem_next;
      bzero_reg   <= bzero_next;
      ovf_reg     <= ovf_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      regwr_reg   <= regwr_next;
      result_reg  <= result_next;
    end
  end

  assign oBusy     = busy_reg;
  assign oDone     = done_reg;
  assign oRegWrite = regwr_reg;
  assign oRd       = rd_reg;
  assign oResult   = result_reg;

endmodule
